pause_button_conditioner: RTL and testbench

- Upstream conditioning stage for the stopwatch core's pause input, in the same slot as the existing button debouncer.
- Synchronises and debounces one raw push-button, then emits:
  - a clean level;
  - one-cycle press and release pulses;
  - a registered pause toggle, so the core consumes a ready-made paused/running flag instead of edge-detecting a level itself.

---
 rtl/pause_button_conditioner.sv | 143 ++++++++++++++
 tb/tb_pause_button_conditioner.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pause_button_conditioner.sv
// Pause-button front end: 2-flop synchroniser, debounce FSM, press/release pulses and a pause toggle.
// Defining PAUSE_BTN_LONG_PRESS_EN adds a one-shot long-hold pulse; otherwise long_press_pulse is 0.
module pause_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
  parameter int unsigned LONG_PRESS_CYCLES = 200000000
) (
  input  logic clk_100mhz,
  input  logic rst,
  input  logic btn_in,
  input  logic toggle_clr,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic pause_toggle,
  output logic long_press_pulse
);

`ifdef PAUSE_BTN_LONG_PRESS_EN
  localparam int CW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [CW-1:0] LP_LAST = CW'(LONG_PRESS_CYCLES - 1);
  localparam logic [CW-1:0] LP_SAT  = CW'(LONG_PRESS_CYCLES);
`else
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
`endif
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_ARM_PRESS   = 2'd1,
    S_HELD        = 2'd2,
    S_ARM_RELEASE = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_level, r_press, r_release, r_toggle;
  logic          w_sync1, w_press, w_release;
`ifdef PAUSE_BTN_LONG_PRESS_EN
  logic          r_long, r_fired, w_long, w_fired_nxt;
`endif

  assign w_sync1 = r_sync[1];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press     = 1'b0;
    w_release   = 1'b0;
`ifdef PAUSE_BTN_LONG_PRESS_EN
    w_long      = 1'b0;
    w_fired_nxt = r_fired;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_sync1) w_state_nxt = S_ARM_PRESS;
      end
      S_ARM_PRESS: begin
        if (!w_sync1) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = S_HELD;
          w_press     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_HELD: begin
        if (!w_sync1) begin
          w_state_nxt = S_ARM_RELEASE;
        end
`ifdef PAUSE_BTN_LONG_PRESS_EN
        // Count saturates and the fired flag survives release bounces: one pulse per hold.
        else if (r_cnt != LP_SAT) begin
          w_cnt_nxt = r_cnt + CW'(1);
          if (r_cnt == LP_LAST && !r_fired) begin
            w_long      = 1'b1;
            w_fired_nxt = 1'b1;
          end
        end
`endif
      end
      S_ARM_RELEASE: begin
        if (w_sync1) begin
          w_state_nxt = S_HELD;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = S_IDLE;
          w_release   = 1'b1;
`ifdef PAUSE_BTN_LONG_PRESS_EN
          w_fired_nxt = 1'b0;
`endif
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_state_nxt != r_state) w_cnt_nxt = '0;
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      r_sync    <= 2'b00;
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_toggle  <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], btn_in};
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= (w_state_nxt == S_HELD) || (w_state_nxt == S_ARM_RELEASE);
      r_press   <= w_press;
      r_release <= w_release;
      // Clear wins over a coincident press toggle.
      if (toggle_clr)   r_toggle <= 1'b0;
      else if (w_press) r_toggle <= ~r_toggle;
    end
  end

`ifdef PAUSE_BTN_LONG_PRESS_EN
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      r_long  <= 1'b0;
      r_fired <= 1'b0;
    end else begin
      r_long  <= w_long;
      r_fired <= w_fired_nxt;
    end
  end
  assign long_press_pulse = r_long;
`else
  assign long_press_pulse = 1'b0;
`endif

  assign btn_level     = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign pause_toggle  = r_toggle;

endmodule

// File: tb/tb_pause_button_conditioner.sv
// Bench for pause_button_conditioner: run-length reference model checked every cycle,
// plus directed scenarios with hand-computed edge timings (DEBOUNCE=4, LONG_PRESS=12).
`timescale 1ns/1ps
module tb_pause_button_conditioner;
  localparam int D = 4;
  localparam int L = 12;

  logic clk_100mhz = 1'b0;
  logic rst;
  logic btn_in;
  logic toggle_clr;
  logic btn_level, press_pulse, release_pulse, pause_toggle, long_press_pulse;

  int n_total = 0;
  int n_bad   = 0;
  logic chk_en = 1'b0;

  pause_button_conditioner #(
    .DEBOUNCE_CYCLES  (D),
    .LONG_PRESS_CYCLES(L)
  ) dut (
    .clk_100mhz      (clk_100mhz),
    .rst             (rst),
    .btn_in          (btn_in),
    .toggle_clr      (toggle_clr),
    .btn_level       (btn_level),
    .press_pulse     (press_pulse),
    .release_pulse   (release_pulse),
    .pause_toggle    (pause_toggle),
    .long_press_pulse(long_press_pulse)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  task automatic check(input string name, input logic act, input logic exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: an edge is accepted once the synchronised input has disagreed with
  // the accepted level on D+1 consecutive clock edges.
  logic m_s0, m_s1, m_lvl, m_press, m_rel, m_tog, m_long, m_fired;
  int   m_run, m_hold;

  always @(posedge clk_100mhz or posedge rst) begin
    logic s;
    if (rst) begin
      m_s0 = 0; m_s1 = 0; m_lvl = 0; m_press = 0; m_rel = 0;
      m_tog = 0; m_long = 0; m_fired = 0; m_run = 0; m_hold = 0;
    end else begin
      s = m_s1;
      m_s1 = m_s0;
      m_s0 = btn_in;
      m_press = 0;
      m_rel   = 0;
      m_long  = 0;
`ifdef PAUSE_BTN_LONG_PRESS_EN
      if (m_lvl && s && m_run == 0) begin
        m_hold++;
        if (m_hold == L && !m_fired) begin
          m_long  = 1;
          m_fired = 1;
        end
      end else begin
        m_hold = 0;
      end
`endif
      if (s != m_lvl) begin
        m_run++;
        if (m_run == D + 1) begin
          m_lvl = s;
          m_run = 0;
          if (s) m_press = 1;
          else begin
            m_rel   = 1;
            m_fired = 0;
          end
        end
      end else begin
        m_run = 0;
      end
      if (toggle_clr)   m_tog = 0;
      else if (m_press) m_tog = ~m_tog;
    end
  end

  always @(negedge clk_100mhz) begin
    if (chk_en && !rst) begin
      check("btn_level",        btn_level,        m_lvl);
      check("press_pulse",      press_pulse,      m_press);
      check("release_pulse",    release_pulse,    m_rel);
      check("pause_toggle",     pause_toggle,     m_tog);
      check("long_press_pulse", long_press_pulse, m_long);
      check("no_overlap",       press_pulse & release_pulse, 1'b0);
    end
  end

  task automatic tick();
    @(posedge clk_100mhz);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn_in = 1'b0;
    toggle_clr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"},   btn_level,        1'b0);
    check({tag, "_press"},   press_pulse,      1'b0);
    check({tag, "_release"}, release_pulse,    1'b0);
    check({tag, "_toggle"},  pause_toggle,     1'b0);
    check({tag, "_long"},    long_press_pulse, 1'b0);
  endtask

  initial begin
    int n_press, n_rel, k_press, len;
    rst = 1'b1;
    btn_in = 1'b0;
    toggle_clr = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (2) tick();

    // Clean press held 30 cycles, then release.
    btn_in = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      check("clean_press", press_pulse, k == 7);
      check("clean_level", btn_level, k >= 7);
      check("clean_toggle", pause_toggle, k >= 7);
`ifdef PAUSE_BTN_LONG_PRESS_EN
      check("clean_long", long_press_pulse, k == 7 + L);
`else
      check("clean_long", long_press_pulse, 1'b0);
`endif
    end
    btn_in = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check("clean_release", release_pulse, k == 7);
      check("clean_rel_level", btn_level, k < 7);
    end

    // Bounce: high 3, low 2, then held.
    do_reset();
    btn_in = 1'b1; repeat (3) tick();
    btn_in = 1'b0; repeat (2) tick();
    btn_in = 1'b1;
    n_press = 0;
    k_press = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (press_pulse) begin
        n_press++;
        k_press = k;
      end
    end
    check_int("bounce_count", n_press, 1);
    check_int("bounce_edge", k_press, 7);
    check("bounce_toggle", pause_toggle, 1'b1);
    btn_in = 1'b0;
    repeat (15) tick();

    // toggle_clr coincident with entry to HELD.
    do_reset();
    btn_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 6) toggle_clr = 1'b1;
      if (k == 7) begin
        toggle_clr = 1'b0;
        check("clr_press", press_pulse, 1'b1);
        check("clr_toggle", pause_toggle, 1'b0);
      end
    end
    btn_in = 1'b0;
    repeat (15) tick();

    // Two full press/release cycles, 10 cycles per phase.
    do_reset();
    n_press = 0;
    n_rel = 0;
    for (int r = 0; r < 2; r++) begin
      btn_in = 1'b1;
      repeat (10) begin tick(); n_press += int'(press_pulse); n_rel += int'(release_pulse); end
      btn_in = 1'b0;
      repeat (10) begin tick(); n_press += int'(press_pulse); n_rel += int'(release_pulse); end
    end
    check_int("two_cycle_press", n_press, 2);
    check_int("two_cycle_release", n_rel, 2);
    check("two_cycle_toggle", pause_toggle, 1'b0);

    // Reset while ARM_PRESS with cnt=2, button kept held.
    do_reset();
    btn_in = 1'b1; repeat (10) tick();
    btn_in = 1'b0; repeat (10) tick();
    check("pre_reset_toggle", pause_toggle, 1'b1);
    btn_in = 1'b1;
    repeat (5) tick();
    #3 rst = 1'b1;
    #1 check_all_zero("midrst");
    #2 rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("midrst_press", press_pulse, k == 7);
      check("midrst_toggle", pause_toggle, k >= 7);
    end
    btn_in = 1'b0;
    repeat (15) tick();

    // Randomised segments with bounces, long holds, clears and async resets.
    do_reset();
    for (int seg = 0; seg < 300; seg++) begin
      btn_in = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(15, 40)) : int'($urandom_range(1, 10));
      for (int c = 0; c < len; c++) begin
        toggle_clr = ($urandom_range(0, 7) == 0);
        tick();
      end
      toggle_clr = 1'b0;
      if ($urandom_range(0, 49) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end
    btn_in = 1'b0;
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
